// File: rtl/alu_seq_pkg.sv
// Shared types and constants for the 2-bit ALU slice sequencer.
package alu_seq_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam int          FN_W_DEF = 4;
    localparam int unsigned FN_ADD   = 0;
    localparam int unsigned FN_AND   = 1;

endpackage

// File: rtl/alu_slice_sequencer.sv
// Drives an external 2-bit combinational ALU slice over a WIDTH-bit operation,
// LSB pair first, with the inter-slice carry held in a register.
module alu_slice_sequencer
    import alu_seq_pkg::*;
#(
    parameter int WIDTH = 16,
    parameter int FN_W  = FN_W_DEF
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic [FN_W-1:0]  req_fn,
    input  logic [WIDTH-1:0] req_a,
    input  logic [WIDTH-1:0] req_b,
    input  logic             req_cin,
    output logic [1:0]       slice_a,
    output logic [1:0]       slice_b,
    output logic [FN_W-1:0]  slice_fn,
    output logic             slice_cin,
    input  logic [1:0]       slice_y,
    input  logic             slice_cout,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic [WIDTH-1:0] rsp_y,
    output logic             rsp_cout,
    output logic             rsp_zero,
    output logic             busy
);

    localparam int NSLICE = WIDTH / 2;
    localparam int IDX_W  = (NSLICE > 1) ? $clog2(NSLICE) : 1;
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NSLICE - 1);

    state_t state_q, state_d;

    logic [WIDTH-1:0] sa_q, sa_d;
    logic [WIDTH-1:0] sb_q, sb_d;
    logic [WIDTH-1:0] res_q, res_d;
    logic [FN_W-1:0]  fn_q, fn_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic             cy_q, cy_d;
    logic             zero_q, zero_d;
    logic [WIDTH-1:0] res_shift;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: if (req_valid) state_d = RUN;
            RUN:  if (idx_q == IDX_LAST) state_d = DONE;
            DONE: if (rsp_ready) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        req_ready = (state_q == IDLE);
        rsp_valid = (state_q == DONE);
        busy      = (state_q == RUN) || (state_q == DONE);
        slice_fn  = fn_q;
        slice_a   = '0;
        slice_b   = '0;
        slice_cin = 1'b0;
        rsp_y     = '0;
        rsp_cout  = 1'b0;
        rsp_zero  = 1'b0;
        if (state_q == RUN) begin
            slice_a   = sa_q[1:0];
            slice_b   = sb_q[1:0];
            slice_cin = cy_q;
        end
        if (state_q == DONE) begin
            rsp_y    = res_q;
            rsp_cout = cy_q;
            rsp_zero = zero_q;
        end
    end

    // Built by shift-then-insert so the WIDTH=2 case needs no empty slice.
    always_comb begin
        res_shift                = res_q >> 2;
        res_shift[WIDTH-1 -: 2]  = slice_y;
    end

    always_comb begin
        sa_d   = sa_q;
        sb_d   = sb_q;
        res_d  = res_q;
        fn_d   = fn_q;
        idx_d  = idx_q;
        cy_d   = cy_q;
        zero_d = zero_q;
        case (state_q)
            IDLE: begin
                if (req_valid) begin
                    sa_d   = req_a;
                    sb_d   = req_b;
                    fn_d   = req_fn;
                    cy_d   = req_cin;
                    idx_d  = '0;
                    res_d  = '0;
                    zero_d = 1'b0;
                end
            end
            RUN: begin
                res_d = res_shift;
                cy_d  = slice_cout;
                sa_d  = sa_q >> 2;
                sb_d  = sb_q >> 2;
                idx_d = idx_q + 1'b1;
                if (idx_q == IDX_LAST) begin
                    zero_d = (res_shift == '0);
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sa_q   <= '0;
            sb_q   <= '0;
            res_q  <= '0;
            fn_q   <= '0;
            idx_q  <= '0;
            cy_q   <= 1'b0;
            zero_q <= 1'b0;
        end else begin
            sa_q   <= sa_d;
            sb_q   <= sb_d;
            res_q  <= res_d;
            fn_q   <= fn_d;
            idx_q  <= idx_d;
            cy_q   <= cy_d;
            zero_q <= zero_d;
        end
    end

endmodule

// File: tb/tb_alu_slice_sequencer.sv
// Scoreboard bench for alu_slice_sequencer with a behavioural 2-bit slice model.
module tb_alu_slice_sequencer;
    import alu_seq_pkg::*;

    localparam int W  = 16;
    localparam int FW = 4;
    localparam logic [FW-1:0] F_ADD = FW'(FN_ADD);
    localparam logic [FW-1:0] F_AND = FW'(FN_AND);

    logic          clk = 1'b0;
    logic          rst_n;
    logic          req_valid;
    logic          req_ready;
    logic [FW-1:0] req_fn;
    logic [W-1:0]  req_a;
    logic [W-1:0]  req_b;
    logic          req_cin;
    logic [1:0]    slice_a;
    logic [1:0]    slice_b;
    logic [FW-1:0] slice_fn;
    logic          slice_cin;
    logic [1:0]    slice_y;
    logic          slice_cout;
    logic          rsp_valid;
    logic          rsp_ready;
    logic [W-1:0]  rsp_y;
    logic          rsp_cout;
    logic          rsp_zero;
    logic          busy;

    always #5 clk = ~clk;

    alu_slice_sequencer #(.WIDTH(W), .FN_W(FW)) dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_ready(req_ready), .req_fn(req_fn),
        .req_a(req_a), .req_b(req_b), .req_cin(req_cin),
        .slice_a(slice_a), .slice_b(slice_b), .slice_fn(slice_fn), .slice_cin(slice_cin),
        .slice_y(slice_y), .slice_cout(slice_cout),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_y(rsp_y),
        .rsp_cout(rsp_cout), .rsp_zero(rsp_zero), .busy(busy)
    );

    function automatic logic [2:0] alu_slice_model(input logic [FW-1:0] fn, input logic [1:0] a,
                                                   input logic [1:0] b, input logic cin);
        if (fn == F_ADD) return {1'b0, a} + {1'b0, b} + {2'b00, cin};
        if (fn == F_AND) return {1'b0, a & b};
        return {1'b0, a | b};
    endfunction

    always_comb {slice_cout, slice_y} = alu_slice_model(slice_fn, slice_a, slice_b, slice_cin);

    typedef struct packed {
        logic [W-1:0] y;
        logic         cout;
        logic         zero;
    } rsp_t;

    rsp_t exp_q[$];

    // Whole-word reference: the full-width sum or bitwise AND.
    function automatic rsp_t ref_op(input logic [FW-1:0] fn, input logic [W-1:0] a,
                                    input logic [W-1:0] b, input logic cin);
        rsp_t r;
        logic [W:0] s;
        if (fn == F_ADD) begin
            s = {1'b0, a} + {1'b0, b} + {{W{1'b0}}, cin};
            r.y = s[W-1:0];
            r.cout = s[W];
        end else begin
            r.y = (fn == F_AND) ? (a & b) : (a | b);
            r.cout = 1'b0;
        end
        r.zero = (r.y == '0);
        return r;
    endfunction

    int n_cmp = 0;
    int n_bad = 0;
    int cyc = 0;
    bit rnd_bp = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
        end
    endtask

    // Monitor: pops one expectation per response handshake.
    initial begin
        rsp_t e;
        forever begin
            @(negedge clk);
            if (rnd_bp) rsp_ready = 1'($urandom_range(0, 1));
            if (rst_n && rsp_valid && rsp_ready) begin
                if (exp_q.size() == 0) begin
                    n_cmp++;
                    n_bad++;
                    $display("FAIL unexpected_rsp: got y=0x%0h with no expected response", rsp_y);
                end else begin
                    e = exp_q.pop_front();
                    chk("rsp_y", 32'(rsp_y), 32'(e.y));
                    chk("rsp_cout", 32'(rsp_cout), 32'(e.cout));
                    chk("rsp_zero", 32'(rsp_zero), 32'(e.zero));
                end
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic check_reset(input string tag);
        chk({tag, "_req_ready"}, 32'(req_ready), 32'd1);
        chk({tag, "_rsp_valid"}, 32'(rsp_valid), 32'd0);
        chk({tag, "_rsp_y"}, 32'(rsp_y), 32'd0);
        chk({tag, "_rsp_cout"}, 32'(rsp_cout), 32'd0);
        chk({tag, "_rsp_zero"}, 32'(rsp_zero), 32'd0);
        chk({tag, "_busy"}, 32'(busy), 32'd0);
        chk({tag, "_slice_a"}, 32'(slice_a), 32'd0);
        chk({tag, "_slice_b"}, 32'(slice_b), 32'd0);
        chk({tag, "_slice_cin"}, 32'(slice_cin), 32'd0);
        chk({tag, "_slice_fn"}, 32'(slice_fn), 32'd0);
    endtask

    task automatic issue_op(input logic [FW-1:0] fn, input logic [W-1:0] a, input logic [W-1:0] b,
                            input logic cin, input bit push, output int acc);
        @(negedge clk);
        req_fn = fn; req_a = a; req_b = b; req_cin = cin; req_valid = 1'b1;
        for (int i = 0; i < 60 && !req_ready; i++) @(negedge clk);
        if (!req_ready) begin
            n_cmp++;
            n_bad++;
            $display("FAIL accept_timeout: req_ready=%0d expected 1", req_ready);
            acc = -1;
            return;
        end
        @(posedge clk);
        #1;
        acc = cyc;
        if (push) exp_q.push_back(ref_op(fn, a, b, cin));
    endtask

    task automatic run_traced(input logic [FW-1:0] fn, input logic [W-1:0] a, input logic [W-1:0] b,
                              input logic cin, output logic [7:0] cinb, output logic [15:0] ab,
                              output int fn_hits, output int lat);
        int acc;
        issue_op(fn, a, b, cin, 1'b1, acc);
        req_valid = 1'b0;
        cinb = '0; ab = '0; fn_hits = 0; lat = -1;
        for (int i = 0; i < 30; i++) begin
            @(negedge clk);
            if (rsp_valid) begin
                lat = cyc - acc;
                break;
            end
            if (i < 8) begin
                cinb[i] = slice_cin;
                ab[2*i +: 2] = slice_a;
                if (slice_fn == fn) fn_hits++;
            end
        end
    endtask

    initial begin
        logic [7:0]  cinb;
        logic [15:0] ab;
        int fn_hits, lat, acc, acc1, acc2, acc3;
        logic [FW-1:0] f;

        rst_n = 1'b0; req_valid = 1'b0; req_fn = '0; req_a = '0; req_b = '0;
        req_cin = 1'b0; rsp_ready = 1'b1;
        #12;
        check_reset("rst");
        @(negedge clk);
        rst_n = 1'b1;

        run_traced(F_ADD, 16'h00FF, 16'h0001, 1'b0, cinb, ab, fn_hits, lat);
        chk("t1_latency", 32'(lat), 32'd8);
        chk("t1_cin_seq", 32'(cinb), 32'h1E);

        run_traced(F_ADD, 16'hFFFF, 16'h0001, 1'b0, cinb, ab, fn_hits, lat);
        chk("t2_latency", 32'(lat), 32'd8);

        run_traced(F_AND, 16'hA5A5, 16'h0FF0, 1'b0, cinb, ab, fn_hits, lat);
        chk("t3_fn_cycles", 32'(fn_hits), 32'd8);
        chk("t3_slice_a_pairs", 32'(ab), 32'hA5A5);

        issue_op(F_ADD, 16'h1357, 16'h2468, 1'b0, 1'b1, acc);
        req_valid = 1'b0;
        rsp_ready = 1'b0;
        for (int i = 0; i < 30 && !rsp_valid; i++) @(negedge clk);
        for (int i = 0; i < 5; i++) begin
            chk("t4_rsp_valid", 32'(rsp_valid), 32'd1);
            chk("t4_rsp_y_hold", 32'(rsp_y), 32'h37BF);
            chk("t4_rsp_cout_hold", 32'(rsp_cout), 32'd0);
            chk("t4_req_ready", 32'(req_ready), 32'd0);
            if (i == 1) begin
                req_fn = F_ADD; req_a = 16'hFFFF; req_b = 16'hFFFF; req_valid = 1'b1;
            end
            if (i == 2) req_valid = 1'b0;
            @(negedge clk);
        end
        @(posedge clk);
        #1;
        rsp_ready = 1'b1;
        repeat (4) @(negedge clk);
        chk("t4_no_extra_busy", 32'(busy), 32'd0);
        chk("t4_no_extra_valid", 32'(rsp_valid), 32'd0);

        issue_op(F_ADD, 16'hFFFF, 16'h0001, 1'b0, 1'b0, acc);
        req_valid = 1'b0;
        repeat (3) @(negedge clk);
        @(posedge clk);
        #2;
        chk("t5_busy_before_rst", 32'(busy), 32'd1);
        rst_n = 1'b0;
        #1;
        check_reset("midrst");
        @(negedge clk);
        rst_n = 1'b1;
        repeat (12) @(negedge clk);
        chk("t5_idle_after_rst", 32'(busy), 32'd0);
        run_traced(F_ADD, 16'h1234, 16'h1111, 1'b0, cinb, ab, fn_hits, lat);
        chk("t5_latency", 32'(lat), 32'd8);

        repeat (3) @(negedge clk);
        issue_op(F_ADD, 16'($urandom), 16'($urandom), 1'($urandom_range(0, 1)), 1'b1, acc1);
        issue_op(F_AND, 16'($urandom), 16'($urandom), 1'b0, 1'b1, acc2);
        issue_op(F_ADD, 16'($urandom), 16'($urandom), 1'($urandom_range(0, 1)), 1'b1, acc3);
        req_valid = 1'b0;
        chk("t6_gap12", 32'(acc2 - acc1), 32'd10);
        chk("t6_gap23", 32'(acc3 - acc2), 32'd10);

        rnd_bp = 1'b1;
        for (int n = 0; n < 24; n++) begin
            f = ($urandom_range(0, 1) == 0) ? F_ADD : F_AND;
            issue_op(f, 16'($urandom), 16'($urandom), 1'($urandom_range(0, 1)), 1'b1, acc);
            req_valid = 1'b0;
        end
        for (int n = 0; n < 4; n++) begin
            issue_op(F_ADD, 16'($urandom), 16'(0) - req_a, 1'b0, 1'b1, acc);
            req_valid = 1'b0;
        end
        @(posedge clk);
        #1;
        rnd_bp = 1'b0;
        rsp_ready = 1'b1;

        for (int i = 0; i < 200 && exp_q.size() != 0; i++) @(negedge clk);
        chk("sb_drain", 32'(exp_q.size()), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
